// File: rtl/usb_rx_frontend.sv
// USB full-speed receive front end: line synchronizer, packet-start detect,
// bit-timing recovery, NRZI decode with bit-unstuffing, shift register and EOP detect.
module usb_rx_frontend (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        d_plus,
    input  logic        d_minus,
    input  logic        timer_clear,
    output logic        d_plus_sync,
    output logic        d_minus_sync,
    output logic        edge_start,
    output logic        shift_enable,
    output logic [15:0] rcv_data,
    output logic        one_byte,
    output logic        two_byte,
    output logic        eop,
    output logic        stuff_err
);

    typedef enum logic [1:0] {IDLE, RUN, EOP} state_t;

    state_t     state, state_next;
    logic       dp_meta, dm_meta, dp_prev;
    logic [2:0] timer;
    logic [2:0] ones;
    logic [3:0] cnt;
    logic       byte_seen;
    logic       last_lvl;

    logic dp_edge, sample, se0, j_state, bit_val, is_stuff, accept, clear_pkt;

    assign dp_edge  = (dp_prev != d_plus_sync);
    assign sample   = (state != IDLE) && (timer == 3'd3);
    assign se0      = !d_plus_sync && !d_minus_sync;
    assign j_state  = d_plus_sync && !d_minus_sync;
    assign bit_val  = (d_plus_sync == last_lvl);
    assign is_stuff = (ones == 3'd6);

    // J->K edge opens a packet; a pending abort wins over the start
    assign edge_start = (state == IDLE) && dp_prev && !d_plus_sync && d_minus_sync && !timer_clear;
    assign accept     = (state == RUN) && sample && !se0 && !is_stuff && !timer_clear;
    assign clear_pkt  = timer_clear || ((state != IDLE) && (state_next == IDLE));

    assign one_byte = byte_seen && (cnt[2:0] == 3'd0);
    assign two_byte = byte_seen && (cnt == 4'd0);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (timer_clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (edge_start)         state_next = RUN;
                RUN:     if (sample && se0)      state_next = EOP;
                EOP:     if (sample && j_state)  state_next = IDLE;
                default:                         state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_meta      <= 1'b1;
            d_plus_sync  <= 1'b1;
            dm_meta      <= 1'b0;
            d_minus_sync <= 1'b0;
            dp_prev      <= 1'b1;
            timer        <= 3'd0;
            ones         <= 3'd0;
            cnt          <= 4'd0;
            byte_seen    <= 1'b0;
            last_lvl     <= 1'b1;
            rcv_data     <= 16'd0;
            shift_enable <= 1'b0;
            eop          <= 1'b0;
            stuff_err    <= 1'b0;
        end else begin
            dp_meta      <= d_plus;
            d_plus_sync  <= dp_meta;
            dm_meta      <= d_minus;
            d_minus_sync <= dm_meta;
            dp_prev      <= d_plus_sync;
            shift_enable <= accept;

            if (clear_pkt) begin
                timer     <= 3'd0;
                ones      <= 3'd0;
                cnt       <= 4'd0;
                byte_seen <= 1'b0;
                eop       <= 1'b0;
            end else if (edge_start) begin
                timer     <= 3'd0;
                ones      <= 3'd0;
                cnt       <= 4'd0;
                byte_seen <= 1'b0;
                last_lvl  <= 1'b1;
                rcv_data  <= 16'd0;
                stuff_err <= 1'b0;
            end else if (state != IDLE) begin
                // every line transition re-centres the sample point
                timer <= dp_edge ? 3'd0 : timer + 3'd1;
                if (sample && (state == RUN)) begin
                    if (se0) begin
                        eop <= 1'b1;
                    end else begin
                        last_lvl <= d_plus_sync;
                        if (is_stuff) begin
                            ones <= 3'd0;
                            if (bit_val) stuff_err <= 1'b1;
                        end else begin
                            ones     <= bit_val ? ones + 3'd1 : 3'd0;
                            rcv_data <= {bit_val, rcv_data[15:1]};
                            cnt      <= cnt + 4'd1;
                            if (cnt == 4'd7) byte_seen <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_frontend.sv
// Directed bench for usb_rx_frontend: NRZI-encodes packets onto D+/D- and checks decode.
module tb_usb_rx_frontend;

    logic        clk = 1'b0;
    logic        n_rst, d_plus, d_minus, timer_clear;
    logic        d_plus_sync, d_minus_sync, edge_start, shift_enable;
    logic [15:0] rcv_data;
    logic        one_byte, two_byte, eop, stuff_err;

    usb_rx_frontend dut (
        .clk(clk), .n_rst(n_rst), .d_plus(d_plus), .d_minus(d_minus),
        .timer_clear(timer_clear), .d_plus_sync(d_plus_sync), .d_minus_sync(d_minus_sync),
        .edge_start(edge_start), .shift_enable(shift_enable), .rcv_data(rcv_data),
        .one_byte(one_byte), .two_byte(two_byte), .eop(eop), .stuff_err(stuff_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int se_cnt = 0, es_cnt = 0, tb_cnt = 0;
    int se0_base, es0_base;
    logic [7:0] bytes[$];
    logic ob_d = 1'b0, tb_d = 1'b0;
    logic lvl;

    // pulse/level-rise monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (shift_enable) se_cnt++;
        if (edge_start) es_cnt++;
        if (one_byte && !ob_d) bytes.push_back(rcv_data[15:8]);
        if (two_byte && !tb_d) tb_cnt++;
        ob_d = one_byte;
        tb_d = two_byte;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input int i);
        return (i < bytes.size()) ? bytes[i] : 8'hxx;
    endfunction

    task automatic line(input logic dp, input logic dm, input int n);
        d_plus  = dp;
        d_minus = dm;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // NRZI: a 0 toggles the line, a 1 holds it (lvl 1 = J)
    task automatic send_bit(input logic b, input int w);
        if (!b) lvl = ~lvl;
        line(lvl, ~lvl, w);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i], 8);
    endtask

    task automatic send_byte_jit(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i], (i % 2 == 0) ? 7 : 9);
    endtask

    task automatic end_packet();
        line(1'b0, 1'b0, 16);
        line(1'b1, 1'b0, 16);
        lvl = 1'b1;
    endtask

    initial begin
        n_rst = 1'b0; d_plus = 1'b1; d_minus = 1'b0; timer_clear = 1'b0; lvl = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sync", {30'd0, d_plus_sync, d_minus_sync}, 32'h2);
        chk("rst_out", {26'd0, edge_start, shift_enable, one_byte, two_byte, eop, stuff_err}, 32'h0);
        chk("rst_data", {16'd0, rcv_data}, 32'h0);
        n_rst = 1'b1;
        line(1'b1, 1'b0, 4);

        // sync byte
        send_byte(8'h80);
        chk("sync_shifts", se_cnt, 8);
        chk("sync_edge", es_cnt, 1);
        chk("sync_byte", {24'd0, byte_at(0)}, 32'h80);
        chk("sync_onebyte", {31'd0, one_byte}, 32'h1);
        chk("sync_twobyte", {31'd0, two_byte}, 32'h0);

        // PID IN and token
        send_byte(8'h69);
        chk("pid_byte", {24'd0, byte_at(1)}, 32'h69);
        chk("pid_twobyte", {31'd0, two_byte}, 32'h1);
        chk("pid_tbcnt", tb_cnt, 1);
        send_byte(8'h34);
        send_byte(8'h12);
        chk("tok_tbcnt", tb_cnt, 2);
        chk("tok_shifts", se_cnt, 32);
        chk("tok_lo", {24'd0, byte_at(2)}, 32'h34);
        chk("tok_hi", {24'd0, byte_at(3)}, 32'h12);

        // EOP: two bit times of SE0 then J
        line(1'b0, 1'b0, 8);
        chk("eop_rise", {31'd0, eop}, 32'h1);
        chk("eop_noshift", se_cnt, 32);
        line(1'b0, 1'b0, 8);
        d_plus = 1'b1; d_minus = 1'b0; lvl = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("eop_hold", {31'd0, eop}, 32'h1);
        @(posedge clk);
        #1;
        chk("eop_fall", {31'd0, eop}, 32'h0);
        line(1'b1, 1'b0, 8);
        chk("idle_onebyte", {31'd0, one_byte}, 32'h0);

        // SE0 glitch in IDLE must not open a packet
        line(1'b0, 1'b0, 8);
        line(1'b1, 1'b0, 8);
        chk("idle_ignore_es", es_cnt, 1);
        chk("idle_ignore_se", se_cnt, 32);

        // six 1s followed by a stuffed 0
        se0_base = se_cnt;
        send_bit(1'b0, 8);
        for (int i = 0; i < 6; i++) send_bit(1'b1, 8);
        chk("stuff_six", se_cnt - se0_base, 7);
        send_bit(1'b0, 8);
        chk("stuff_dropped", se_cnt - se0_base, 7);
        send_bit(1'b0, 8);
        chk("stuff_shifts", se_cnt - se0_base, 8);
        chk("stuff_byte", {24'd0, byte_at(4)}, 32'h7e);
        chk("stuff_noerr", {31'd0, stuff_err}, 32'h0);
        end_packet();

        // stuff violation: seventh consecutive 1
        send_bit(1'b0, 8);
        for (int i = 0; i < 6; i++) send_bit(1'b1, 8);
        send_bit(1'b1, 8);
        chk("stuff_err_set", {31'd0, stuff_err}, 32'h1);
        end_packet();
        chk("stuff_err_sticky", {31'd0, stuff_err}, 32'h1);

        // jittered 7/9 clk bits; new packet also clears stuff_err
        se0_base = se_cnt;
        send_byte_jit(8'h80);
        chk("stuff_err_clr", {31'd0, stuff_err}, 32'h0);
        send_byte_jit(8'h69);
        chk("jit_shifts", se_cnt - se0_base, 16);
        chk("jit_sync", {24'd0, byte_at(5)}, 32'h80);
        chk("jit_pid", {24'd0, byte_at(6)}, 32'h69);
        end_packet();

        // timer_clear abort
        send_byte(8'h80);
        line(1'b0, 1'b0, 8);
        chk("tc_pre", {29'd0, one_byte, two_byte, eop}, 32'h5);
        timer_clear = 1'b1;
        @(posedge clk);
        #1;
        timer_clear = 1'b0;
        chk("tc_clear", {29'd0, one_byte, two_byte, eop}, 32'h0);
        line(1'b0, 1'b0, 4);
        line(1'b1, 1'b0, 16);
        lvl = 1'b1;
        es0_base = es_cnt;
        send_bit(1'b0, 8);
        chk("tc_restart", es_cnt - es0_base, 1);
        end_packet();

        // reset mid-packet
        send_byte(8'h80);
        send_bit(1'b0, 8);
        n_rst = 1'b0; d_plus = 1'b1; d_minus = 1'b0; lvl = 1'b1;
        #1;
        chk("mrst_out", {26'd0, edge_start, shift_enable, one_byte, two_byte, eop, stuff_err}, 32'h0);
        chk("mrst_data", {16'd0, rcv_data}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        es0_base = es_cnt;
        se0_base = se_cnt;
        line(1'b1, 1'b0, 24);
        chk("mrst_quiet", (es_cnt - es0_base) + (se_cnt - se0_base), 0);
        send_byte(8'h80);
        chk("mrst_restart_es", es_cnt - es0_base, 1);
        chk("mrst_restart_se", se_cnt - se0_base, 8);
        chk("mrst_byte", {24'd0, rcv_data[15:8]}, 32'h80);
        end_packet();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_rx_frontend.md
USB_RX_FRONTEND -- requirements
Module: usb_rx_frontend

Interface
REQ-001 SHALL have port clk  input  1  system clock; nominal 8 clk periods per USB bit time.
REQ-002 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port d_plus  input  1  raw D+ line, asynchronous to clk.
REQ-004 SHALL have port d_minus  input  1  raw D- line, asynchronous to clk.
REQ-005 SHALL have port timer_clear  input  1  synchronous request to abandon the packet and return to IDLE.
REQ-006 SHALL have port d_plus_sync  output  1  D+ after 2-flop synchronizer.
REQ-007 SHALL have port d_minus_sync  output  1  D- after 2-flop synchronizer.
REQ-008 SHALL have port edge_start  output  1  single-cycle pulse marking the start of a packet.
REQ-009 SHALL have port shift_enable  output  1  single-cycle pulse per accepted (non-stuffed, non-SE0) data bit.
REQ-010 SHALL have port rcv_data  output  16  shift register of decoded bits, newest bit at [15].
REQ-011 SHALL have port one_byte  output  1  level, high while the accepted-bit count is a nonzero multiple of 8.
REQ-012 SHALL have port two_byte  output  1  level, high while the accepted-bit count is a nonzero multiple of 16.
REQ-013 SHALL have port eop  output  1  level, high from the SE0 sample until the J sample ending the packet.
REQ-014 SHALL have port stuff_err  output  1  sticky flag set on a bit-stuffing violation.

Function
REQ-015 SHALL synchronize d_plus and d_minus through two flops each; latency 2 clk from pin to *_sync.
REQ-016 SHALL implement FSM states IDLE, RUN, EOP; reset state IDLE.
REQ-017 In IDLE, a d_plus_sync 1->0 transition with d_minus_sync=1 SHALL pulse edge_start for that cycle; next state RUN.
REQ-018 SHALL run a 3-bit bit timer in RUN and EOP: increments every clk mod 8; set to 0 on edge_start and on any d_plus_sync transition; a sample occurs when the timer equals 3.
REQ-019 At a sample in RUN with d_plus_sync=0 and d_minus_sync=0 (SE0), the block SHALL set eop the next cycle and go to EOP; there SHALL be no shift_enable and no count change.
REQ-020 At a non-SE0 sample in RUN, the decoded bit SHALL be 1 if d_plus_sync equals the previously sampled level, else 0 (NRZI); the previous level SHALL be 1 on entering RUN.
REQ-021 SHALL count consecutive decoded 1s; on reaching 6, the next sample is a stuff bit: discarded, no shift_enable, ones count cleared.
REQ-022 A stuff bit decoding as 1 SHALL set stuff_err, which holds until the next edge_start or reset.
REQ-023 For each accepted bit, shift_enable SHALL pulse one cycle after the sample and rcv_data SHALL shift right with the bit entering [15] in the same cycle.
REQ-024 SHALL keep a 4-bit accepted-bit counter (mod 16) and a byte_seen flag set after the 8th bit; one_byte = byte_seen AND count[2:0]==0; two_byte = byte_seen AND count==0.
REQ-025 In EOP, a sample with d_plus_sync=1 and d_minus_sync=0 (J) SHALL return the FSM to IDLE, with eop cleared one cycle after that sample; other samples keep EOP.
REQ-026 Entering IDLE SHALL clear the bit counter, byte_seen, ones count, timer and eop; rcv_data SHALL hold its value until the next edge_start, then clear to 0.
REQ-027 timer_clear=1 SHALL force IDLE on the next clk with the REQ-026 clears; it takes priority over all other events in the same cycle.
REQ-028 Transitions on the line while in IDLE, other than REQ-017, SHALL be ignored.

Reset
REQ-029 On n_rst low: synchronizer flops d_plus=1 and d_minus=0; all other outputs 0; rcv_data 0; FSM IDLE; all counters 0.
REQ-030 Reset asserted mid-packet SHALL abort immediately, with no edge_start, shift_enable or eop pulse after release until a new K edge arrives.

Verification
REQ-031 Sync KJKJKJKK at 8 clk/bit -> 8 shift_enable pulses; one_byte rises after the 8th; rcv_data[15:8]=8'b10000000.
REQ-032 Sync followed by PID 0x69 (IN) and a 16-bit token -> two_byte high after bits 16 and 32; rcv_data[15:8]=8'h69 while one_byte is high after bit 16.
REQ-033 Six decoded 1s followed by a stuffed 0 -> exactly 6 shift_enable pulses for 7 bit times; stuff_err stays 0; replace the stuffed 0 with a 1 -> stuff_err=1.
REQ-034 Packet then 2 bit times of SE0 then J -> eop rises after the first SE0 sample and falls one clk after the J sample; the FSM is in IDLE after that.
REQ-035 Bit period jittered to 7 and 9 clk -> timer resyncs on each edge; decoded bytes unchanged.
REQ-036 timer_clear pulse mid-byte -> one_byte, two_byte and eop are 0 the next clk; the next K edge yields edge_start.
